// File: rtl/dino_if.sv
// dino_if -- frame/button/collision inputs and game-state outputs of the
// dino game controller, bundled as one port.
//
//   new_frame  single-cycle pulse once per video frame
//   btn_jump   jump/start button level, already synchronised to clk
//   collision  dino/obstacle pixel overlap, valid in any cycle
//   state      game state (IDLE=00, RUN=01, JUMP=10, OVER=11)
//   dino_y     dino height above ground in pixels
//   score      4-digit BCD current score
//   hi_score   4-digit BCD high score
//
// master: the side that drives frame/button/collision (video + input logic)
// slave : the controller itself
interface dino_if;
  logic        new_frame;
  logic        btn_jump;
  logic        collision;
  logic [1:0]  state;
  logic [7:0]  dino_y;
  logic [15:0] score;
  logic [15:0] hi_score;

  modport master (
    output new_frame, btn_jump, collision,
    input  state, dino_y, score, hi_score
  );

  modport slave (
    input  new_frame, btn_jump, collision,
    output state, dino_y, score, hi_score
  );
endinterface

// File: rtl/dino_ctrl.sv
// dino_ctrl -- game-state controller for a side-scrolling dino game.
//
// Tracks the game state, the dino's jump arc (integer ballistic motion with
// constant gravity) and a saturating 4-digit BCD score.  All game updates
// happen only in new_frame cycles; button presses and collisions arriving
// between frames are latched in sticky flags so they are never missed.
//
// Parameters
//   JUMP_V0           initial upward velocity, pixels/frame (1..21)
//   GRAVITY           velocity decrement per frame (1..JUMP_V0)
//   FRAMES_PER_POINT  frames per score increment (1..63)
//
// Ports
//   clk   system clock, rising edge
//   rst   asynchronous reset, active low
//   bus   dino_if.slave (new_frame, btn_jump, collision in;
//         state, dino_y, score, hi_score out)
//
// Optional feature
//   DINO_HIGH_SCORE_EN  when defined, hi_score captures the final score on
//                       entry to OVER if it beats the stored value; when not
//                       defined, hi_score is tied to zero.
module dino_ctrl #(
  parameter int JUMP_V0          = 16,
  parameter int GRAVITY          = 1,
  parameter int FRAMES_PER_POINT = 6
) (
  input  logic   clk,
  input  logic   rst,
  dino_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    JUMP = 2'b10,
    OVER = 2'b11
  } state_t;

  localparam logic signed [7:0] V0         = 8'(JUMP_V0);
  localparam logic signed [7:0] GRAV       = 8'(GRAVITY);
  localparam logic signed [7:0] VEL_START  = V0 - GRAV;
  localparam logic        [5:0] LAST_FRAME = 6'(FRAMES_PER_POINT - 1);

  state_t             state_q, state_d;
  logic        [7:0] dino_y_q, dino_y_d;
  logic signed [7:0] vel_q, vel_d;
  logic       [15:0] score_q, score_d;
  logic        [5:0] frame_cnt_q, frame_cnt_d;
  logic              jump_req_q, jump_req_d;
  logic              hit_q, hit_d;
  logic              btn_q;

  logic              btn_rise;
  logic              in_play;
  logic              jump_eff;
  logic              hit_eff;
  logic signed [8:0] y_ext, v_ext, y_sum;

  // Increment a 4-digit BCD value with per-digit carry, holding at 9999.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  assign btn_rise = bus.btn_jump & ~btn_q;
  assign in_play  = (state_q == RUN) || (state_q == JUMP);

  // Frame decisions see the sticky flags plus whatever arrives in the frame
  // cycle itself, so an event coinciding with new_frame is not lost.
  assign jump_eff = jump_req_q | btn_rise;
  assign hit_eff  = hit_q | (bus.collision & in_play);

  // Height and velocity widened to 9-bit signed so a downward step below
  // ground shows up as a non-positive sum instead of wrapping.
  assign y_ext = {1'b0, dino_y_q};
  assign v_ext = {vel_q[7], vel_q};
  assign y_sum = y_ext + v_ext;

  // NOTE: every variable assigned in this block gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    dino_y_d    = dino_y_q;
    vel_d       = vel_q;
    score_d     = score_q;
    frame_cnt_d = frame_cnt_q;
    jump_req_d  = bus.new_frame ? 1'b0 : jump_eff;
    hit_d       = bus.new_frame ? 1'b0 : hit_eff;

    if (bus.new_frame) begin
      // Scoring runs independently of the transition, so the frame that
      // ends the game still earns its point.
      if (in_play) begin
        if (frame_cnt_q == LAST_FRAME) begin
          frame_cnt_d = 6'd0;
          score_d     = bcd_inc(score_q);
        end else begin
          frame_cnt_d = frame_cnt_q + 6'd1;
        end
      end

      unique case (state_q)
        IDLE: begin
          if (jump_eff) begin
            state_d     = RUN;
            score_d     = 16'h0000;
            frame_cnt_d = 6'd0;
          end
        end
        RUN: begin
          if (hit_eff) begin
            state_d = OVER;
          end else if (jump_eff) begin
            state_d  = JUMP;
            dino_y_d = V0;
            vel_d    = VEL_START;
          end
        end
        JUMP: begin
          // jump_req is deliberately not examined here: no double jump.
          if (hit_eff) begin
            state_d = OVER;
          end else if (y_sum <= 9'sd0) begin
            state_d  = RUN;
            dino_y_d = 8'd0;
            vel_d    = 8'sd0;
          end else begin
            dino_y_d = y_sum[7:0];
            vel_d    = vel_q - GRAV;
          end
        end
        OVER: begin
          if (jump_eff) begin
            state_d     = RUN;
            score_d     = 16'h0000;
            frame_cnt_d = 6'd0;
            dino_y_d    = 8'd0;
            vel_d       = 8'sd0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      dino_y_q    <= 8'd0;
      vel_q       <= 8'sd0;
      score_q     <= 16'h0000;
      frame_cnt_q <= 6'd0;
      jump_req_q  <= 1'b0;
      hit_q       <= 1'b0;
      btn_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dino_y_q    <= dino_y_d;
      vel_q       <= vel_d;
      score_q     <= score_d;
      frame_cnt_q <= frame_cnt_d;
      jump_req_q  <= jump_req_d;
      hit_q       <= hit_d;
      btn_q       <= bus.btn_jump;
    end
  end

`ifdef DINO_HIGH_SCORE_EN
  logic [15:0] hi_score_q;
  logic        enter_over;

  // score_d already includes any increment earned on the final frame.
  assign enter_over = bus.new_frame && in_play && (state_d == OVER);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_score_q <= 16'h0000;
    end else if (enter_over && (score_d > hi_score_q)) begin
      hi_score_q <= score_d;
    end
  end

  assign bus.hi_score = hi_score_q;
`else
  assign bus.hi_score = 16'h0000;
`endif

  assign bus.state  = state_q;
  assign bus.dino_y = dino_y_q;
  assign bus.score  = score_q;

endmodule

// File: tb/tb_dino_ctrl.sv
// tb_dino_ctrl -- directed self-checking bench for dino_ctrl.
//
// Main instance: JUMP_V0=4, GRAVITY=1, FRAMES_PER_POINT=6.
// Second instance with FRAMES_PER_POINT=1 reaches the 9998/9999 saturation
// region in about ten thousand frames.
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge that follows the rising edge which consumed them.
module tb_dino_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dino_if bus ();
  dino_if bus2 ();

  dino_ctrl #(
    .JUMP_V0         (4),
    .GRAVITY         (1),
    .FRAMES_PER_POINT(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  dino_ctrl #(
    .JUMP_V0         (4),
    .GRAVITY         (1),
    .FRAMES_PER_POINT(1)
  ) dut_sat (
    .clk(clk),
    .rst(rst),
    .bus(bus2)
  );

`ifdef DINO_HIGH_SCORE_EN
  localparam logic [15:0] HI_FIRST = 16'h0012;
  localparam logic [15:0] HI_BEST  = 16'h0042;
`else
  localparam logic [15:0] HI_FIRST = 16'h0000;
  localparam logic [15:0] HI_BEST  = 16'h0000;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic frame();
    @(negedge clk) bus.new_frame = 1'b1;
    @(negedge clk) bus.new_frame = 1'b0;
  endtask

  task automatic frames(input int n);
    repeat (n) frame();
  endtask

  task automatic press();
    @(negedge clk) bus.btn_jump = 1'b1;
    @(negedge clk) bus.btn_jump = 1'b0;
  endtask

  task automatic bump();
    @(negedge clk) bus.collision = 1'b1;
    @(negedge clk) bus.collision = 1'b0;
  endtask

  initial begin
    int arc [9];
    arc = '{4, 7, 9, 10, 10, 9, 7, 4, 0};

    rst            = 1'b0;
    bus.new_frame  = 1'b0;
    bus.btn_jump   = 1'b0;
    bus.collision  = 1'b0;
    bus2.new_frame = 1'b0;
    bus2.btn_jump  = 1'b0;
    bus2.collision = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_state",  16'(bus.state), 16'd0);
    check("rst_dino_y", 16'(bus.dino_y), 16'd0);
    check("rst_score",  bus.score, 16'h0000);
    check("rst_hi",     bus.hi_score, 16'h0000);
    @(negedge clk) rst = 1'b1;

    // Frames without a press keep IDLE
    frames(2);
    check("idle_hold", 16'(bus.state), 16'd0);

    // Idle start
    press();
    frame();
    check("start_state", 16'(bus.state), 16'd1);
    check("start_score", bus.score, 16'h0000);

    // Scoring: 59 then 60 frames in RUN
    frames(59);
    check("score_59", bus.score, 16'h0009);
    frame();
    check("score_60", bus.score, 16'h0010);

    // Jump arc, with a second press mid-air that must be ignored
    press();
    for (int i = 0; i < 9; i++) begin
      if (i == 4) press();
      frame();
      check($sformatf("arc_y%0d", i), 16'(bus.dino_y), 16'(arc[i]));
      check($sformatf("arc_st%0d", i), 16'(bus.state), (i < 8) ? 16'd2 : 16'd1);
    end
    check("arc_score", bus.score, 16'h0011);

    // Collision mid-jump at dino_y = 9
    press();
    frames(3);
    check("hit_pre_y", 16'(bus.dino_y), 16'd9);
    check("hit_pre_score", bus.score, 16'h0012);
    bump();
    frame();
    check("hit_state", 16'(bus.state), 16'd3);
    check("hit_y", 16'(bus.dino_y), 16'd9);
    check("hit_score", bus.score, 16'h0012);
    bump();
    frames(7);
    check("over_state", 16'(bus.state), 16'd3);
    check("over_y", 16'(bus.dino_y), 16'd9);
    check("over_score", bus.score, 16'h0012);
    check("hi_first", bus.hi_score, HI_FIRST);

    // Restart, game over at 0042 on a scoring frame
    press();
    frame();
    check("rs1_state", 16'(bus.state), 16'd1);
    check("rs1_score", bus.score, 16'h0000);
    check("rs1_y", 16'(bus.dino_y), 16'd0);
    frames(251);
    check("rs1_pre", bus.score, 16'h0041);
    bump();
    frame();
    check("rs1_over", 16'(bus.state), 16'd3);
    check("rs1_final", bus.score, 16'h0042);
    check("rs1_hi", bus.hi_score, HI_BEST);

    // Restart, game over at 0017; high score must stay 0042
    press();
    frame();
    check("rs2_score", bus.score, 16'h0000);
    frames(102);
    bump();
    frame();
    check("rs2_over", 16'(bus.state), 16'd3);
    check("rs2_final", bus.score, 16'h0017);
    check("rs2_hi", bus.hi_score, HI_BEST);

    // Saturation on the one-frame-per-point instance
    @(negedge clk) bus2.btn_jump = 1'b1;
    @(negedge clk) bus2.btn_jump = 1'b0;
    @(negedge clk) bus2.new_frame = 1'b1;
    @(negedge clk) bus2.new_frame = 1'b0;
    check("sat_start", 16'(bus2.state), 16'd1);
    bus2.new_frame = 1'b1;
    repeat (9998) @(negedge clk);
    bus2.new_frame = 1'b0;
    check("sat_9998", bus2.score, 16'h9998);
    bus2.new_frame = 1'b1;
    repeat (12) @(negedge clk);
    bus2.new_frame = 1'b0;
    check("sat_9999", bus2.score, 16'h9999);
    check("sat_state", 16'(bus2.state), 16'd1);

    // Async reset mid-jump
    press();
    frame();
    frames(6);
    check("ar_score", bus.score, 16'h0001);
    press();
    frames(2);
    check("ar_pre_y", 16'(bus.dino_y), 16'd7);
    check("ar_pre_st", 16'(bus.state), 16'd2);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("ar_state", 16'(bus.state), 16'd0);
    check("ar_y", 16'(bus.dino_y), 16'd0);
    check("ar_score0", bus.score, 16'h0000);
    check("ar_hi", bus.hi_score, 16'h0000);
    check("ar_sat_score", bus2.score, 16'h0000);
    @(negedge clk) rst = 1'b1;
    frame();
    check("ar_idle", 16'(bus.state), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
